// File: rtl/cla_arb_pkg.sv
// Shared definitions for the CLA adder arbiter: op encodings, FSM states
// and small op-decoding helpers.
package cla_arb_pkg;

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_SUB16 = 2'b01;
  localparam logic [1:0] OP_ADD32 = 2'b10;
  localparam logic [1:0] OP_SUB32 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } state_e;

  // Bit 0 of the op selects subtraction (A + ~B + 1).
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

  // Bit 1 of the op selects a two-pass 32-bit operation.
  function automatic logic op_is_wide(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/cla_add_arbiter_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate /
// propagate feeding the inter-group carries. Ovfl is signed overflow
// (carry into bit 15 xor carry out of bit 15).
module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out,
  output logic        Ovfl
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [16:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;

  // Bit and group generate/propagate, lookahead carries between groups
  always_comb begin
    g_s    = A & B;
    p_s    = A ^ B;
    c_s    = 17'd0;
    c_s[0] = C_in;
    gg_s   = 4'd0;
    gp_s   = 4'd0;
    for (int k = 0; k < 4; k++) begin
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      gp_s[k] = &p_s[4*k +: 4];
      for (int i = 0; i < 3; i++) begin
        c_s[4*k+i+1] = g_s[4*k+i] | (p_s[4*k+i] & c_s[4*k+i]);
      end
      c_s[4*k+4] = gg_s[k] | (gp_s[k] & c_s[4*k]);
    end
    S     = p_s ^ c_s[15:0];
    C_out = c_s[16];
    Ovfl  = c_s[15] ^ c_s[16];
  end

endmodule

// File: rtl/cla_add_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers which requester won
// the last accepted grant; on a tie the other requester wins. Reset leaves
// the pointer as if r1 won last, so r0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_r;  // 1: requester 1 was granted last

  // Grant decode: single request wins outright, tie goes to the one not granted last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (accept) begin
      last_r <= gnt[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Shares one 16-bit CLA between two valid/ready requesters. Round-robin
// grant in IDLE, one pass for 16-bit ops, two passes (low, then high with
// chained carry) for 32-bit ops, then a registered response held until
// the consumer takes it.
module cla_add_arbiter #(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [1:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [1:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_ovfl
);

  import cla_arb_pkg::*;

  state_e      state_r;
  state_e      next_state_s;

  logic        idle_s;
  logic [1:0]  req_s;
  logic [1:0]  gnt_s;
  logic        accept_s;

  logic [1:0]  sel_op_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;

  logic        op_sub_r;
  logic        op_wide_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        id_r;
  logic [31:0] sum_r;
  logic        carry_r;
  logic        ovfl_r;
  logic        rsp_valid_r;

  logic [15:0] cla_a_s;
  logic [15:0] cla_b_s;
  logic        cla_cin_s;
  logic [15:0] cla_s_s;
  logic        cla_cout_s;
  logic        cla_ovfl_s;

  // Requests are only offered in IDLE and outside reset, so ready never
  // rises for an op the FSM cannot take.
  assign idle_s   = (state_r == IDLE) && rst_n;
  assign req_s    = {r1_valid, r0_valid} & {2{idle_s}};
  assign accept_s = |gnt_s;
  assign r0_ready = gnt_s[0];
  assign r1_ready = gnt_s[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_s),
    .accept (accept_s),
    .gnt    (gnt_s)
  );

  // Payload of the granted requester
  always_comb begin
    sel_op_s = r0_op;
    sel_a_s  = r0_a;
    sel_b_s  = r0_b;
    if (gnt_s[1]) begin
      sel_op_s = r1_op;
      sel_a_s  = r1_a;
      sel_b_s  = r1_b;
    end else begin
      sel_op_s = r0_op;
      sel_a_s  = r0_a;
      sel_b_s  = r0_b;
    end
  end

  // CLA operand muxes: low half with C_in=sub, high half with chained carry
  always_comb begin
    cla_a_s   = a_r[15:0];
    cla_b_s   = b_r[15:0];
    cla_cin_s = op_sub_r;
    if (state_r == HI) begin
      cla_a_s   = a_r[31:16];
      cla_b_s   = b_r[31:16];
      cla_cin_s = carry_r;
    end else begin
      cla_a_s   = a_r[15:0];
      cla_b_s   = b_r[15:0];
      cla_cin_s = op_sub_r;
    end
    if (op_sub_r) begin
      cla_b_s = ~cla_b_s;
    end else begin
      cla_b_s = cla_b_s;
    end
  end

  CLA_16bit u_cla (
    .A     (cla_a_s),
    .B     (cla_b_s),
    .C_in  (cla_cin_s),
    .S     (cla_s_s),
    .C_out (cla_cout_s),
    .Ovfl  (cla_ovfl_s)
  );

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = accept_s ? LO : IDLE;
      LO:      next_state_s = op_wide_r ? HI : RSP;
      HI:      next_state_s = RSP;
      RSP:     next_state_s = rsp_ready ? IDLE : RSP;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Op capture, per-pass result registers and response valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sub_r    <= 1'b0;
      op_wide_r   <= 1'b0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      id_r        <= 1'b0;
      sum_r       <= 32'd0;
      carry_r     <= 1'b0;
      ovfl_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_sub_r  <= op_is_sub(sel_op_s);
            op_wide_r <= op_is_wide(sel_op_s) & WIDE_EN;
            a_r       <= sel_a_s;
            b_r       <= sel_b_s;
            id_r      <= gnt_s[1];
          end else begin
            op_sub_r  <= op_sub_r;
          end
        end
        LO: begin
          // Carry out of the low pass equals (A15&B15)|((A15^B15)&~S15)
          sum_r[15:0]  <= cla_s_s;
          sum_r[31:16] <= op_wide_r ? sum_r[31:16] : {16{cla_s_s[15]}};
          carry_r      <= cla_cout_s;
          ovfl_r       <= cla_ovfl_s;
          rsp_valid_r  <= ~op_wide_r;
        end
        HI: begin
          sum_r[31:16] <= cla_s_s;
          ovfl_r       <= cla_ovfl_s;
          rsp_valid_r  <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = id_r;
  assign rsp_sum   = sum_r;
  assign rsp_ovfl  = ovfl_r;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter: reset values, 16/32-bit arithmetic
// with latency, round-robin ordering, response hold and mid-op reset.
module tb_cla_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [1:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovfl;
  logic [31:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  cla_add_arbiter #(.WIDE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_ovfl(rsp_ovfl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for the requester's ready; returns at the negedge after accept.
  task automatic wait_accept(input int who, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((who == 0) ? r0_ready : r1_ready) got = 1'b1;
      @(negedge clk);
      if (got) break;
    end
  endtask

  // Called at the negedge right after accept; lat counts cycles from the accept cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    #1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    r0_op = 2'b00; r1_op = 2'b00; r0_a = 32'd0; r0_b = 32'd0; r1_a = 32'd0; r1_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_ovfl !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b id=%b ov=%b exp 0 0 0", rsp_valid, rsp_id, rsp_ovfl);
    end
    checks++;
    if (rsp_sum !== 32'h0) begin
      errors++; $display("FAIL reset_sum got %h exp 00000000", rsp_sum);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b%b v=%b exp 00 0", r1_ready, r0_ready, rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_add16;
    bit got; int lat;
    // r0 ADD16 0x7FFF + 1 -> 0x8000, signed overflow, sign-extended
    r0_valid = 1'b1; r0_op = 2'b00; r0_a = 32'h0000_7FFF; r0_b = 32'h0000_0001;
    wait_accept(0, got);
    r0_valid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL add16_accept got 0 exp 1"); end
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add16_latency got %0d exp 2", lat); end
    checks++;
    if (rsp_sum !== 32'hFFFF_8000 || rsp_ovfl !== 1'b1 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL add16_result got %h ov=%b id=%b exp ffff8000 1 0", rsp_sum, rsp_ovfl, rsp_id);
    end
    release_rsp();
    // r1 SUB16 0x8000 - 1 -> 0x7FFF, signed overflow, upper zero
    r1_valid = 1'b1; r1_op = 2'b01; r1_a = 32'h0000_8000; r1_b = 32'h0000_0001;
    wait_accept(1, got);
    r1_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (!got || rsp_sum !== 32'h0000_7FFF || rsp_ovfl !== 1'b1 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL sub16_ovfl got %h ov=%b id=%b exp 00007fff 1 1", rsp_sum, rsp_ovfl, rsp_id);
    end
    release_rsp();
    // r0 SUB16 3 - 5 -> 0xFFFE, no overflow; upper operand bits ignored
    r0_valid = 1'b1; r0_op = 2'b01; r0_a = 32'hABCD_0003; r0_b = 32'h1234_0005;
    wait_accept(0, got);
    r0_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (!got || rsp_sum !== 32'hFFFF_FFFE || rsp_ovfl !== 1'b0) begin
      errors++; $display("FAIL sub16_neg got %h ov=%b exp fffffffe 0", rsp_sum, rsp_ovfl);
    end
    release_rsp();
  endtask

  task automatic test_sub32;
    bit got; int lat;
    r1_valid = 1'b1; r1_op = 2'b11; r1_a = 32'h0001_0000; r1_b = 32'h0000_0001;
    wait_accept(1, got);
    r1_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (!got || lat !== 3) begin errors++; $display("FAIL sub32_latency got %0d exp 3", lat); end
    checks++;
    if (rsp_sum !== 32'h0000_FFFF || rsp_ovfl !== 1'b0 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL sub32_result got %h ov=%b id=%b exp 0000ffff 0 1", rsp_sum, rsp_ovfl, rsp_id);
    end
    release_rsp();
  endtask

  task automatic test_add32;
    bit got; int lat;
    r0_valid = 1'b1; r0_op = 2'b10; r0_a = 32'h7FFF_FFFF; r0_b = 32'h0000_0001;
    wait_accept(0, got);
    r0_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (!got || lat !== 3 || rsp_sum !== 32'h8000_0000 || rsp_ovfl !== 1'b1) begin
      errors++; $display("FAIL add32_ovfl got %h ov=%b lat=%0d exp 80000000 1 3", rsp_sum, rsp_ovfl, lat);
    end
    release_rsp();
    r0_valid = 1'b1; r0_op = 2'b10; r0_a = 32'hFFFF_FFFF; r0_b = 32'h0000_0001;
    wait_accept(0, got);
    r0_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (!got || rsp_sum !== 32'h0000_0000 || rsp_ovfl !== 1'b0) begin
      errors++; $display("FAIL add32_wrap got %h ov=%b exp 00000000 0", rsp_sum, rsp_ovfl);
    end
    release_rsp();
  endtask

  task automatic test_round_robin;
    int gseq[$]; int rseq[$]; int gcyc[$];
    bit both_hi; bit sum_bad;
    both_hi = 1'b0; sum_bad = 1'b0;
    rst_n = 1'b0;
    r0_valid = 1'b1; r0_op = 2'b00; r0_a = 32'h1; r0_b = 32'h1;
    r1_valid = 1'b1; r1_op = 2'b00; r1_a = 32'h2; r1_b = 32'h2;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL rr_ready_in_reset got %b%b exp 00", r1_ready, r0_ready);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30 && rseq.size() < 4; c++) begin
      #1;
      if (r0_ready && r1_ready) both_hi = 1'b1;
      if (r0_ready) begin gseq.push_back(0); gcyc.push_back(c); end
      if (r1_ready) begin gseq.push_back(1); gcyc.push_back(c); end
      if (rsp_valid) begin
        rseq.push_back(int'(rsp_id));
        if (rsp_sum !== (rsp_id ? 32'h4 : 32'h2)) sum_bad = 1'b1;
      end
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    checks++;
    if (both_hi) begin errors++; $display("FAIL rr_exclusive got both ready exp one"); end
    checks++;
    if (gseq.size() < 4 || gseq[0] != 0 || gseq[1] != 1 || gseq[2] != 0 || gseq[3] != 1) begin
      errors++; $display("FAIL rr_grant_order got n=%0d exp 0,1,0,1", gseq.size());
    end
    checks++;
    if (rseq.size() < 4 || rseq[0] != 0 || rseq[1] != 1 || rseq[2] != 0 || rseq[3] != 1 || sum_bad) begin
      errors++; $display("FAIL rr_rsp_order got n=%0d sum_bad=%b exp ids 0,1,0,1", rseq.size(), sum_bad);
    end
    checks++;
    if (gcyc.size() < 2 || (gcyc[1] - gcyc[0]) != 3) begin
      errors++; $display("FAIL rr_throughput got gap %0d exp 3", (gcyc.size() < 2) ? -1 : gcyc[1] - gcyc[0]);
    end
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_hold;
    bit got; int lat; bit bad;
    bad = 1'b0;
    r0_valid = 1'b1; r0_op = 2'b00; r0_a = 32'h0000_1234; r0_b = 32'h0000_1111;
    wait_accept(0, got);
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_op = 2'b00; r1_a = 32'h5; r1_b = 32'h6;
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_2345 || rsp_id !== 1'b0 ||
          rsp_ovfl !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b sum=%h id=%b rdy=%b%b exp 1 00002345 0 00",
                 i, rsp_valid, rsp_sum, rsp_id, r1_ready, r0_ready);
      end
    end
    release_rsp();
    #1;
    checks++;
    if (r1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_next_accept got rdy1=%b v=%b exp 1 0", r1_ready, rsp_valid);
    end
    @(negedge clk);
    r1_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (rsp_sum !== 32'h0000_000B || rsp_id !== 1'b1) begin
      errors++; $display("FAIL hold_follow_op got %h id=%b exp 0000000b 1", rsp_sum, rsp_id);
    end
    release_rsp();
  endtask

  task automatic test_reset_midop;
    bit got; int lat;
    r0_valid = 1'b1; r0_op = 2'b10; r0_a = 32'h7FFF_FFFF; r0_b = 32'h0000_0001;
    wait_accept(0, got);
    r0_valid = 1'b0;
    @(negedge clk);           // op is now in its high pass
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_valid got %b exp 0", rsp_valid); end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_ovfl !== 1'b0) begin
      errors++; $display("FAIL midop_cleared got v=%b sum=%h ov=%b exp 0 0 0", rsp_valid, rsp_sum, rsp_ovfl);
    end
    r0_valid = 1'b1; r0_op = 2'b00; r0_a = 32'h10;  r0_b = 32'h20;
    r1_valid = 1'b1; r1_op = 2'b00; r1_a = 32'h100; r1_b = 32'h200;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL midop_tie got rdy=%b%b exp 01", r1_ready, r0_ready);
    end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (lat !== 2 || rsp_id !== 1'b0 || rsp_sum !== 32'h0000_0030 || rsp_ovfl !== 1'b0) begin
      errors++; $display("FAIL midop_new_op got %h id=%b lat=%0d exp 00000030 0 2", rsp_sum, rsp_id, lat);
    end
    release_rsp();
  endtask

  initial begin
    test_reset();
    test_add16();
    test_sub32();
    test_add32();
    test_round_robin();
    test_rsp_hold();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
